// File: rtl/frame_fetch_ctrl.sv
// Frame fetch controller: streams FRAME_WORDS words from memory through a small
// buffer to a display, with continuous-frame repeat, abort and frame counting.
module frame_fetch_ctrl #(
    parameter int WORD_W      = 36,
    parameter int FRAME_WORDS = 3201,
    parameter int ADDR_W      = 12,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [WORD_W-1:0] i_mem_data,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       addr;
    logic                    inflight;
    logic                    inflight_last;
    logic [WORD_W-1:0]       buf_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   buf_last;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           occ;
    logic [7:0]              frame_count;

    logic rd_issue, last_rd, push, pop, last_pop;

    // Reads are throttled so buffered plus in-flight words never exceed the buffer.
    always_comb begin
        rd_issue = (state == FETCH) && !i_abort &&
                   ((occ + CW'(inflight)) < DEPTH_C);
        last_rd  = rd_issue && (addr == LAST_ADDR);
        push     = inflight;
        pop      = (occ != '0) && i_ready;
        last_pop = pop && buf_last[rd_ptr] && (state == DRAIN) && !i_abort;
    end

    assign o_mem_rd      = rd_issue;
    assign o_mem_addr    = addr;
    assign o_valid       = (occ != '0);
    assign o_data        = buf_data[rd_ptr];
    assign o_busy        = (state != IDLE);
    assign o_frame_done  = last_pop;
    assign o_frame_count = frame_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            buf_last      <= '0;
            frame_count   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) buf_data[i] <= '0;
        end else if (i_abort) begin
            // Abort drops buffered words and the pending read return.
            state         <= IDLE;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= last_rd;
            if (rd_issue) addr <= last_rd ? '0 : addr + 1'b1;

            if (push) begin
                buf_data[wr_ptr] <= i_mem_data;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= FETCH;
                        addr  <= '0;
                    end
                end
                FETCH: begin
                    if (last_rd) state <= DRAIN;
                end
                DRAIN: begin
                    if (last_pop) begin
                        frame_count <= frame_count + 1'b1;
                        state       <= i_continuous ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/frame_fetch_ctrl.md
FRAME_FETCH_CTRL -- requirements
Module: frame_fetch_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 36, meaning image word width in bits.
REQ-002 SHALL have parameter FRAME_WORDS, default 3201, meaning words per frame.
REQ-003 SHALL have parameter ADDR_W, default 12, meaning memory address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of 2, >=2).
REQ-005 i_clk  input  1  sole clock, all logic on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_start  input  1  start frame transfer; sampled only in IDLE.
REQ-008 i_continuous  input  1  when 1 at frame end, restart next frame automatically.
REQ-009 i_abort  input  1  terminate transfer and flush.
REQ-010 o_mem_rd  output  1  memory read strobe, one word per asserted cycle.
REQ-011 o_mem_addr  output  ADDR_W  read address, valid while o_mem_rd=1.
REQ-012 i_mem_data  input  WORD_W  read data, valid exactly one cycle after o_mem_rd.
REQ-013 o_valid  output  1  o_data holds a word for the display.
REQ-014 o_data  output  WORD_W  head-of-buffer word.
REQ-015 i_ready  input  1  display accepts o_data this cycle.
REQ-016 o_busy  output  1  state is not IDLE.
REQ-017 o_frame_done  output  1  one-cycle pulse when the last word of a frame is accepted.
REQ-018 o_frame_count  output  8  completed-frame counter.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN.
REQ-020 IDLE -> FETCH when i_start=1 and i_abort=0; address counter = 0.
REQ-021 In FETCH, o_mem_rd SHALL be 1 iff buffer occupancy + in-flight reads < FIFO_DEPTH; in-flight is at most 1.
REQ-022 Each issued read SHALL increment the address by 1; the read at FRAME_WORDS-1 SHALL be the last of the frame and the counter SHALL then wrap to 0.
REQ-023 FETCH -> DRAIN on the cycle the read at FRAME_WORDS-1 is issued.
REQ-024 Returned i_mem_data SHALL be written to the buffer the cycle after the read strobe; no word is ever dropped or duplicated.
REQ-025 o_valid SHALL be 1 iff buffer non-empty; a transfer occurs when o_valid and i_ready are both 1.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged, and words SHALL leave in address order.
REQ-027 o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-028 In DRAIN, when the final word (address FRAME_WORDS-1) transfers: o_frame_done pulses that cycle and o_frame_count increments, wrapping 255 -> 0.
REQ-029 On that same cycle: i_continuous=1 -> FETCH from address 0 (first read next cycle); else -> IDLE.
REQ-030 i_abort=1 in any state SHALL force IDLE next cycle, flush buffer, cancel in-flight data, set address 0, o_mem_rd=0, no o_frame_done, o_frame_count unchanged.
REQ-031 i_abort has priority over i_start and over frame completion in the same cycle.
REQ-032 i_start while busy SHALL be ignored.
REQ-033 o_busy SHALL be 1 in FETCH and DRAIN, 0 in IDLE.

Reset
REQ-034 With i_rst_n=0 at a clock edge: state IDLE, buffer empty, address 0, in-flight cleared, o_mem_rd=0, o_valid=0, o_data=0, o_busy=0, o_frame_done=0, o_frame_count=0.
REQ-035 Reset mid-transfer SHALL discard all buffered and in-flight words; the first read after the next i_start is address 0.

Verification (FRAME_WORDS=8, FIFO_DEPTH=4, memory word = address)
REQ-036 i_ready=1 constantly, pulse i_start -> addresses 0..7 read on consecutive cycles, o_data 0..7 in order, one o_frame_done, o_frame_count=1, then IDLE.
REQ-037 i_ready=0 after start -> exactly 4 reads (addr 0..3), o_mem_rd then held 0, o_data=0 stable; release i_ready -> fetch resumes at addr 4.
REQ-038 i_continuous=1, i_ready=1 -> three frames stream back-to-back, address wraps 7 -> 0, o_frame_done pulses 3 times, o_frame_count=3.
REQ-039 i_abort at word 5 with i_start in same cycle -> IDLE next cycle, o_valid=0, no done pulse, count unchanged; later i_start re-reads from addr 0.
REQ-040 o_frame_count at 255 plus one frame -> count 0; i_rst_n=0 during FETCH -> all outputs at reset values next cycle.
